// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
// Contents: owner_e tags the requester whose read data returns next cycle;
//           STARVE_MAX_DEF is the default fetch starvation limit.
package mem_arb_pkg;

  // Who owns the response coming back from the memory on the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  // Consecutive denied fetch cycles tolerated before fetch is forced to win.
  localparam int unsigned STARVE_MAX_DEF = 4;

endpackage : mem_arb_pkg

// File: rtl/arb_starve_cnt.sv
// Fetch starvation counter: counts consecutive cycles where fetch requests
// but is not granted, saturating at STARVE_MAX; o_force_if is raised while
// the count sits at the limit so that fetch wins the next contested cycle.
// Ports: clk/rst_n (async active-low), i_if_req, i_if_gnt in; o_force_if out.
module arb_starve_cnt #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_if_req,
  input  logic i_if_gnt,
  output logic o_force_if
);

  localparam int unsigned  CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] r_cnt;

  // Any grant or a dropped request ends the starvation episode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_if_req || i_if_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_force_if = (r_cnt == CNT_MAX);

endmodule : arb_starve_cnt

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch (IF)
// and load/store (LS). Grant is combinational (LS priority); the read
// response is steered to the owning requester one cycle after the grant.
// Ports: clk, reset (async active-low); if_* fetch port; ls_* load/store
// port; mem_* memory port (mem_rdata valid the cycle after a read strobe).
// Build option: define ARB_STARVE_GUARD_EN to let a fetch starved for
// STARVE_MAX consecutive cycles win the next contested cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N          = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset,
  // instruction fetch requester
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [N-1:0]  if_rdata,
  // load/store requester
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [N-1:0]  ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [N-1:0]  ls_rdata,
  // memory port
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata
);

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be at least 1");
  end

  logic   w_force_if;
  logic   w_if_win;
  logic   w_ls_win;
  owner_e w_owner_nxt;
  owner_e r_owner;
  logic   r_ls_store;

  // ---------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .i_if_req   (if_req),
    .i_if_gnt   (if_gnt),
    .o_force_if (w_force_if)
  );
`else
  assign w_force_if = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Grant: LS wins contention unless the guard forces IF. Grants are
  // gated with reset so nothing reaches the memory while reset is low.
  // ---------------------------------------------------------------------
  assign w_if_win = if_req & (~ls_req | w_force_if);
  assign w_ls_win = ls_req & ~w_if_win;

  assign if_gnt = reset & w_if_win;
  assign ls_gnt = reset & w_ls_win;

  // ---------------------------------------------------------------------
  // Memory port, driven from the winner in the same cycle
  // ---------------------------------------------------------------------
  assign mem_en = if_gnt | ls_gnt;
  assign mem_we = ls_gnt & ls_we;

  always_comb begin
    mem_addr = '0;
    if (ls_gnt) begin
      mem_addr = ls_addr;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  assign mem_wdata = mem_we ? ls_wdata : '0;

  // ---------------------------------------------------------------------
  // Response owner: tracks the single access in flight. A new grant and
  // the previous cycle's response overlap freely since the memory
  // returns data in exactly one cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (if_gnt) begin
      w_owner_nxt = OWN_IF;
    end else if (ls_gnt) begin
      w_owner_nxt = OWN_LS;
    end
  end

  // Reset drops any outstanding response, so no rvalid follows release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner    <= OWN_NONE;
      r_ls_store <= 1'b0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_ls_store <= ls_gnt & ls_we;
    end
  end

  // ---------------------------------------------------------------------
  // Response steering; idle rdata outputs read 0. A store ack carries 0
  // rather than whatever stale data the memory holds on its output.
  // ---------------------------------------------------------------------
  assign if_rvalid = (r_owner == OWN_IF);
  assign ls_rvalid = (r_owner == OWN_LS);

  assign if_rdata = if_rvalid ? mem_rdata : '0;
  assign ls_rdata = (ls_rvalid && !r_ls_store) ? mem_rdata : '0;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [N-1:0]  if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [N-1:0]  ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [N-1:0]  ls_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic [N-1:0]  mem_rdata = '0;

  int n_chk = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .N          (N),
    .AW         (AW),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory: read data appears after the clock edge.
  bit [31:0] mem [bit [31:0]];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
      end else begin
        mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  bit guard_on;
  bit exp_if;
  bit prev_if;

  initial begin
`ifdef ARB_STARVE_GUARD_EN
    guard_on = 1'b1;
`else
    guard_on = 1'b0;
`endif
    mem[32'h100] = 32'h0050_0093;
    mem[32'h200] = 32'h1234_5678;

    // ---- reset held low with both requests pending
    reset    = 1'b0;
    if_req   = 1'b1;
    if_addr  = 32'h100;
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 32'h204;
    ls_wdata = 32'hCAFE_F00D;
    tick;
    tick;
    #1;
    chk("rst_if_gnt",    64'(if_gnt),    64'd0);
    chk("rst_ls_gnt",    64'(ls_gnt),    64'd0);
    chk("rst_mem_en",    64'(mem_en),    64'd0);
    chk("rst_mem_we",    64'(mem_we),    64'd0);
    chk("rst_mem_addr",  64'(mem_addr),  64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_if_rvalid", 64'(if_rvalid), 64'd0);
    chk("rst_ls_rvalid", 64'(ls_rvalid), 64'd0);
    chk("rst_owner",     64'(dut.r_owner), 64'(OWN_NONE));

    // ---- release reset under contention: LS load wins first
    tick;
    reset   = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h200;
    #1;
    chk("cont_ls_gnt",   64'(ls_gnt),   64'd1);
    chk("cont_if_gnt",   64'(if_gnt),   64'd0);
    chk("cont_mem_addr", 64'(mem_addr), 64'h200);
    chk("cont_mem_we",   64'(mem_we),   64'd0);

    // LS response and IF grant in the same cycle
    tick;
    ls_req = 1'b0;
    #1;
    chk("cont_ls_rvalid", 64'(ls_rvalid), 64'd1);
    chk("cont_ls_rdata",  64'(ls_rdata),  64'h1234_5678);
    chk("cont_if_gnt2",   64'(if_gnt),    64'd1);
    chk("cont_mem_addr2", 64'(mem_addr),  64'h100);
    chk("cont_if_rv0",    64'(if_rvalid), 64'd0);

    tick;
    if_req = 1'b0;
    #1;
    chk("cont_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("cont_if_rdata",  64'(if_rdata),  64'h0050_0093);
    chk("cont_ls_rv_off", 64'(ls_rvalid), 64'd0);
    chk("cont_ls_rd_off", 64'(ls_rdata),  64'd0);
    chk("idle_mem_en",    64'(mem_en),    64'd0);

    // ---- fetch only
    tick;
    chk("pulse_if_rv",  64'(if_rvalid), 64'd0);
    chk("idle_if_rd",   64'(if_rdata),  64'd0);
    if_req  = 1'b1;
    if_addr = 32'h100;
    #1;
    chk("fo_if_gnt",   64'(if_gnt),   64'd1);
    chk("fo_ls_gnt",   64'(ls_gnt),   64'd0);
    chk("fo_mem_en",   64'(mem_en),   64'd1);
    chk("fo_mem_we",   64'(mem_we),   64'd0);
    chk("fo_mem_addr", 64'(mem_addr), 64'h100);
    tick;
    if_req = 1'b0;
    #1;
    chk("fo_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("fo_if_rdata",  64'(if_rdata),  64'h0050_0093);

    // ---- store (memory output still holds the fetch word)
    tick;
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 32'h204;
    ls_wdata = 32'hDEAD_BEEF;
    #1;
    chk("st_ls_gnt",    64'(ls_gnt),    64'd1);
    chk("st_mem_we",    64'(mem_we),    64'd1);
    chk("st_mem_addr",  64'(mem_addr),  64'h204);
    chk("st_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    tick;
    ls_we   = 1'b0;
    #1;
    chk("st_ls_rvalid", 64'(ls_rvalid), 64'd1);
    chk("st_ls_rdata",  64'(ls_rdata),  64'd0);
    chk("st_if_rvalid", 64'(if_rvalid), 64'd0);
    // back-to-back load of the stored word
    chk("ld_ls_gnt",    64'(ls_gnt),    64'd1);
    chk("ld_mem_we",    64'(mem_we),    64'd0);
    tick;
    ls_req = 1'b0;
    #1;
    chk("ld_ls_rvalid", 64'(ls_rvalid), 64'd1);
    chk("ld_ls_rdata",  64'(ls_rdata),  64'hDEAD_BEEF);
    tick;

    // ---- starvation: both requesting for 10 cycles
    prev_if = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (c == 1) begin
        if_req  = 1'b1;
        if_addr = 32'h100;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h200;
      end
      #1;
      exp_if = guard_on && (c == 5 || c == 10);
      chk($sformatf("sv_if_gnt_c%0d", c),   64'(if_gnt),   64'(exp_if));
      chk($sformatf("sv_ls_gnt_c%0d", c),   64'(ls_gnt),   64'(!exp_if));
      chk($sformatf("sv_mem_addr_c%0d", c), 64'(mem_addr), exp_if ? 64'h100 : 64'h200);
      if (c > 1) begin
        chk($sformatf("sv_if_rv_c%0d", c), 64'(if_rvalid), 64'(prev_if));
        chk($sformatf("sv_ls_rv_c%0d", c), 64'(ls_rvalid), 64'(!prev_if));
      end
      prev_if = exp_if;
    end
    tick;
    if_req = 1'b0;
    ls_req = 1'b0;
    tick;

    // ---- reset asserted the cycle after a load grant
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h200;
    #1;
    chk("ra_ls_gnt", 64'(ls_gnt), 64'd1);
    tick;
    ls_req = 1'b0;
    reset  = 1'b0;
    #1;
    chk("ra_ls_rv_rst", 64'(ls_rvalid), 64'd0);
    chk("ra_ls_rd_rst", 64'(ls_rdata),  64'd0);
    chk("ra_mem_en",    64'(mem_en),    64'd0);
    tick;
    reset = 1'b1;
    #1;
    chk("ra_ls_rv_rel", 64'(ls_rvalid), 64'd0);
    chk("ra_owner",     64'(dut.r_owner), 64'(OWN_NONE));
    tick;
    chk("ra_ls_rv_post", 64'(ls_rvalid), 64'd0);
    chk("ra_if_rv_post", 64'(if_rvalid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-port synchronous memory between the instruction-fetch requester and the load/store requester of the RISC-V core. It selects one requester per cycle, drives the memory port, and returns read data one cycle later to whichever requester owns the outstanding access. It sits between the core's fetch/data interfaces and the unified memory, replacing separate instruction and data memories.

## Interface
Parameters:
- N, 32, data width.
- AW, 32, address width.
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win; only used with the starvation guard.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  N  fetch read data.
- ls_req  in  1  load/store request.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  AW  load/store address.
- ls_wdata  in  N  store data.
- ls_gnt  out  1  load/store request accepted this cycle.
- ls_rvalid  out  1  load data valid, or store completion ack.
- ls_rdata  out  N  load data; 0 on store ack.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  N  memory write data.
- mem_rdata  in  N  memory read data, valid the cycle after the mem_en read.

## Operation
- Grant logic is combinational. At most one grant per cycle. mem_* is driven from the winner in the same cycle. mem_en = if_gnt | ls_gnt.
- Only ls_req asserted: LS wins. Only if_req asserted: IF wins. Both asserted: LS wins unless the starvation guard forces IF.
- IF accesses are always reads. mem_we = ls_gnt & ls_we.
- Requester rule: hold req, addr, we and wdata stable until gnt. A new request may be presented the cycle after gnt, so back-to-back accesses run at one per cycle.
- Response owner register, owner ∈ {OWN_NONE, OWN_IF, OWN_LS}:
  - Loaded each cycle with the winner.
  - Loaded with OWN_NONE when no request is granted.
- Response outputs:
  - owner = OWN_IF: if_rvalid = 1, if_rdata = mem_rdata.
  - owner = OWN_LS: ls_rvalid = 1; ls_rdata = mem_rdata for a load, 0 for a store. The store/load distinction is registered alongside owner.
  - Inactive rdata outputs read 0.
- The requester that does not win sees gnt = 0 and keeps its request pending. Nothing is queued inside the block.

## Timing
- Grant latency: 0 cycles, combinational from req.
- Read data latency: 1 cycle after gnt. The rvalid pulse lasts exactly 1 cycle.
- Store ack: ls_rvalid 1 cycle after gnt.
- Reset values:
  - owner = OWN_NONE; starvation counter = 0.
  - While reset is low, all gnt, rvalid and mem_en/mem_we outputs are forced to 0; rdata, mem_addr and mem_wdata are 0.
- Reset asserted mid-access: the outstanding response is dropped. No rvalid is issued after reset releases.
- Simultaneous grant and response: a grant in cycle t and the response for the cycle t-1 grant coexist; both are handled the same cycle.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter increments each cycle that if_req = 1 and if_gnt = 0, saturating at STARVE_MAX.
  - When the counter equals STARVE_MAX, IF wins the next contested cycle.
  - The counter clears on if_gnt or when if_req = 0.
- ARB_STARVE_GUARD_EN undefined: strict LS priority. The counter and STARVE_MAX are unused.

## Structure
- Package mem_arb_pkg:
  - owner_e enum (OWN_NONE, OWN_IF, OWN_LS).
  - Default STARVE_MAX constant.
- One sub-module, arb_starve_cnt: the saturating counter and force-IF flag. It is instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- Reset: hold reset = 0 with both requests asserted. Required: all gnt, rvalid and mem_en = 0. Release reset: first grant goes to LS.
- Fetch only: if_req with if_addr = 0x100, memory returns 0x00500093. Required: if_gnt same cycle, mem_addr = 0x100, next cycle if_rvalid = 1 with if_rdata = 0x00500093.
- Contention: if_req and ls_req (load 0x200) together. Required: ls_gnt, ls_rvalid next cycle; then IF granted the following cycle.
- Store: ls_we = 1, ls_addr = 0x204, ls_wdata = 0xDEADBEEF. Required: mem_we = 1 with that data, ls_rvalid = 1 and ls_rdata = 0 next cycle, if_rvalid stays 0.
- Starvation, guard enabled, STARVE_MAX = 4: ls_req held high for 10 cycles with if_req high. Required: if_gnt in cycle 5, LS resumes in cycle 6. With the guard disabled: no if_gnt for all 10 cycles.
- Reset mid-access: grant a load, assert reset the next cycle. Required: no ls_rvalid, owner = OWN_NONE after release.
